// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequences a bank of NUMLINES dcache_line instances.
// Presents CPU requests to the bank, muxes the hitting line's data back,
// and on a global miss fills a round-robin victim through the single
// memory-controller port.
// Optional: define DCACHE_CTRL_PERF_EN to enable hit/miss counters.
module dcache_ctrl #(
    parameter int NUMLINES  = 4,
    parameter int LINEWORDS = 32,
    parameter int ADDRBITS  = 32,
    parameter int DATABITS  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDRBITS-1:0]          cpu_addr,
    input  logic                         cpu_rdreq,
    input  logic                         cpu_wrreq,
    output logic [DATABITS-1:0]          cpu_out,
    output logic                         cpu_valid,
    output logic                         cpu_busy,
    output logic [NUMLINES-1:0]          line_fill,
    input  logic [NUMLINES*DATABITS-1:0] line_out,
    input  logic [NUMLINES-1:0]          line_valid,
    input  logic [NUMLINES-1:0]          line_miss,
    input  logic [NUMLINES*ADDRBITS-1:0] line_mem_addr,
    input  logic [NUMLINES-1:0]          line_mem_rdreq,
    input  logic [NUMLINES-1:0]          line_mem_wrreq,
    output logic [NUMLINES-1:0]          line_mem_valid,
    output logic [ADDRBITS-1:0]          mem_addr,
    output logic                         mem_rdreq,
    output logic                         mem_wrreq,
    input  logic                         mem_valid,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);

    localparam int PTRW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
    localparam int CNTW = $clog2(LINEWORDS) + 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(LINEWORDS - 1);
    localparam logic [PTRW-1:0] LAST_LINE = PTRW'(NUMLINES - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, SETTLE} state_t;

    state_t              state, state_nx;
    logic [PTRW-1:0]     victim;
    logic [CNTW-1:0]     beat_cnt;
    logic                settle_cnt;
    logic                req;
    logic                any_hit;
    logic                all_miss;
    logic                beat;
    logic [DATABITS-1:0] hit_data;

    // The address goes straight to the lines; the controller never needs it.
    logic unused_addr;
    assign unused_addr = ^cpu_addr;

    // A simultaneous rd+wr is a write, but either way it is one request here.
    assign req      = cpu_rdreq | cpu_wrreq;
    assign any_hit  = |line_valid;
    assign all_miss = &line_miss;
    // Only read-side beats fill the line; flush (write) beats are not counted.
    assign beat     = (state == FILL) && mem_valid && !line_mem_wrreq[victim];

    // Hit data mux, lowest hitting line wins.
    always_comb begin
        hit_data = '0;
        for (int i = NUMLINES - 1; i >= 0; i--)
            if (line_valid[i]) hit_data = line_out[i*DATABITS +: DATABITS];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and all handshake/memory-port outputs.
    always_comb begin
        state_nx       = state;
        cpu_out        = '0;
        cpu_valid      = 1'b0;
        cpu_busy       = 1'b0;
        line_fill      = '0;
        line_mem_valid = '0;
        mem_addr       = '0;
        mem_rdreq      = 1'b0;
        mem_wrreq      = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nx = LOOKUP;
            end
            LOOKUP: begin
                if (!req) begin
                    state_nx = IDLE;
                end else if (any_hit) begin
                    cpu_valid = 1'b1;
                    cpu_out   = hit_data;
                    state_nx  = IDLE;
                end else if (all_miss) begin
                    line_fill[victim] = 1'b1;
                    cpu_busy          = 1'b1;
                    state_nx          = FILL;
                end
            end
            FILL: begin
                cpu_busy               = 1'b1;
                mem_addr               = line_mem_addr[victim*ADDRBITS +: ADDRBITS];
                mem_rdreq              = line_mem_rdreq[victim];
                mem_wrreq              = line_mem_wrreq[victim];
                line_mem_valid[victim] = mem_valid;
                if (beat && beat_cnt == LAST_BEAT) state_nx = SETTLE;
            end
            SETTLE: begin
                // Two cycles so the line finishes its post-fill breather.
                cpu_busy = 1'b1;
                if (settle_cnt) state_nx = LOOKUP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Beat counter, settle timer and round-robin victim pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            victim     <= '0;
            beat_cnt   <= '0;
            settle_cnt <= 1'b0;
        end else begin
            if (|line_fill)
                beat_cnt <= '0;
            else if (beat)
                beat_cnt <= beat_cnt + 1'b1;
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
            if (state == SETTLE && settle_cnt)
                victim <= (victim == LAST_LINE) ? '0 : victim + 1'b1;
        end
    end

`ifdef DCACHE_CTRL_PERF_EN
    logic [31:0] hit_q, miss_q;

    // Free-running hit/miss counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (cpu_valid)  hit_q  <= hit_q + 1'b1;
            if (|line_fill) miss_q <= miss_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: random line data, masks and beat
// gaps, checked against a small model (victim pointer, hit/miss tallies).
module tb_dcache_ctrl;
    localparam int NL = 4, LW = 32, AB = 32, DB = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [AB-1:0]     cpu_addr;
    logic              cpu_rdreq, cpu_wrreq;
    logic [DB-1:0]     cpu_out;
    logic              cpu_valid, cpu_busy;
    logic [NL-1:0]     line_fill;
    logic [NL*DB-1:0]  line_out;
    logic [NL-1:0]     line_valid, line_miss;
    logic [NL*AB-1:0]  line_mem_addr;
    logic [NL-1:0]     line_mem_rdreq, line_mem_wrreq, line_mem_valid;
    logic [AB-1:0]     mem_addr;
    logic              mem_rdreq, mem_wrreq, mem_valid;
    logic [31:0]       hit_count, miss_count;

    int errors = 0, checks = 0;
    int exp_victim = 0, exp_hits = 0, exp_misses = 0;

    dcache_ctrl #(.NUMLINES(NL), .LINEWORDS(LW), .ADDRBITS(AB), .DATABITS(DB)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rdreq(cpu_rdreq),
        .cpu_wrreq(cpu_wrreq), .cpu_out(cpu_out), .cpu_valid(cpu_valid),
        .cpu_busy(cpu_busy), .line_fill(line_fill), .line_out(line_out),
        .line_valid(line_valid), .line_miss(line_miss), .line_mem_addr(line_mem_addr),
        .line_mem_rdreq(line_mem_rdreq), .line_mem_wrreq(line_mem_wrreq),
        .line_mem_valid(line_mem_valid), .mem_addr(mem_addr), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_valid(mem_valid), .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_addr = '0; cpu_rdreq = 1'b0; cpu_wrreq = 1'b0;
        line_out = '0; line_valid = '0; line_miss = '0;
        line_mem_addr = '0; line_mem_rdreq = '0; line_mem_wrreq = '0;
        mem_valid = 1'b0;
    endtask

    task automatic randomize_lines();
        for (int i = 0; i < NL; i++) begin
            line_out[i*DB +: DB]      = $urandom;
            line_mem_addr[i*AB +: AB] = $urandom;
        end
    endtask

    task automatic start_request();
        cpu_addr  = $urandom;
        cpu_rdreq = 1'($urandom_range(0, 1));
        cpu_wrreq = ~cpu_rdreq | 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        mem_valid = 1'b1;
        #1;
        checks++;
        if ({cpu_valid, cpu_busy, mem_rdreq, mem_wrreq} !== 4'b0 || cpu_out !== '0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b rd=%b wr=%b out=%h addr=%h, want all 0",
                     cpu_valid, cpu_busy, mem_rdreq, mem_wrreq, cpu_out, mem_addr);
        end
        checks++;
        if (line_fill !== '0 || line_mem_valid !== '0) begin
            errors++;
            $display("FAIL reset_line_ports: fill=%b lmv=%b, want 0", line_fill, line_mem_valid);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d, want 0", hit_count, miss_count);
        end
        cyc(); cyc();
        reset = 1'b0;
        mem_valid = 1'b0;
        exp_victim = 0; exp_hits = 0; exp_misses = 0;
        cyc();
    endtask

    task automatic test_hit();
        logic [NL-1:0] mask;
        logic [DB-1:0] want;
        int idx;
        randomize_lines();
        start_request();
        line_valid = '0; line_miss = '0;
        #1;
        checks++;
        if (cpu_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_idle_cycle: cpu_valid=%b, want 0", cpu_valid);
        end
        cyc();
        mask = NL'($urandom_range(1, (1 << NL) - 1));
        line_valid = mask;
        line_miss  = ~mask;
        #1;
        idx = 0;
        for (int i = NL - 1; i >= 0; i--) if (mask[i]) idx = i;
        want = line_out[idx*DB +: DB];
        checks++;
        if (cpu_valid !== 1'b1 || cpu_out !== want) begin
            errors++;
            $display("FAIL hit_data: valid=%b out=%h, want 1 %h (mask %b)", cpu_valid, cpu_out, want, mask);
        end
        checks++;
        if (line_fill !== '0 || cpu_busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_no_fill: fill=%b busy=%b, want 0 0", line_fill, cpu_busy);
        end
        exp_hits++;
        cyc();
        cpu_rdreq = 1'b0; cpu_wrreq = 1'b0; line_valid = '0; line_miss = '0;
        #1;
        checks++;
        if (cpu_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_one_cycle: cpu_valid=%b after hit, want 0", cpu_valid);
        end
        cyc();
    endtask

    task automatic test_miss(input int flush);
        int v, beats, guard;
        logic [NL-1:0] onehot;
        v = exp_victim;
        onehot = '0;
        onehot[v] = 1'b1;
        randomize_lines();
        start_request();
        cyc();
        line_miss = '1; line_valid = '0;
        #1;
        checks++;
        if (line_fill !== onehot || cpu_busy !== 1'b1 || cpu_valid !== 1'b0) begin
            errors++;
            $display("FAIL miss_fill: fill=%b busy=%b valid=%b, want %b 1 0", line_fill, cpu_busy, cpu_valid, onehot);
        end
        exp_misses++;
        cyc();
        line_miss = '0;
        #1;
        checks++;
        if (line_fill !== '0) begin
            errors++;
            $display("FAIL fill_pulse_width: fill=%b in second cycle, want 0", line_fill);
        end
        for (int b = 0; b < flush; b++) begin
            randomize_lines();
            line_mem_wrreq = onehot;
            line_mem_rdreq = NL'($urandom) & ~onehot;
            mem_valid = 1'b1;
            #1;
            checks++;
            if (mem_wrreq !== 1'b1 || mem_rdreq !== 1'b0 || mem_addr !== line_mem_addr[v*AB +: AB] ||
                line_mem_valid !== onehot) begin
                errors++;
                $display("FAIL flush_route: wr=%b rd=%b addr=%h lmv=%b, want 1 0 %h %b",
                         mem_wrreq, mem_rdreq, mem_addr, line_mem_valid, line_mem_addr[v*AB +: AB], onehot);
            end
            cyc();
        end
        beats = 0; guard = 0;
        while (beats < LW && guard < 400) begin
            line_mem_addr[v*AB +: AB] = $urandom;
            line_mem_rdreq = onehot | NL'($urandom);
            line_mem_wrreq = NL'($urandom) & ~onehot;
            mem_valid = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (mem_rdreq !== 1'b1 || mem_wrreq !== 1'b0 || mem_addr !== line_mem_addr[v*AB +: AB] ||
                line_mem_valid !== (mem_valid ? onehot : '0) || cpu_busy !== 1'b1 || cpu_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_beat%0d: rd=%b wr=%b addr=%h lmv=%b busy=%b valid=%b", beats,
                         mem_rdreq, mem_wrreq, mem_addr, line_mem_valid, cpu_busy, cpu_valid);
            end
            if (mem_valid) beats++;
            guard++;
            cyc();
        end
        checks++;
        if (beats != LW) begin
            errors++;
            $display("FAIL fill_budget: only %0d beats in %0d cycles, want %0d", beats, guard, LW);
        end
        // Line still requesting and memory still strobing: both must be blocked.
        mem_valid = 1'b1;
        line_valid = onehot;
        line_out[v*DB +: DB] = $urandom;
        #1;
        checks++;
        if (mem_rdreq !== 1'b0 || line_mem_valid !== '0 || cpu_busy !== 1'b1 || cpu_valid !== 1'b0) begin
            errors++;
            $display("FAIL settle1: rd=%b lmv=%b busy=%b valid=%b, want 0 0 1 0",
                     mem_rdreq, line_mem_valid, cpu_busy, cpu_valid);
        end
        cyc();
        checks++;
        if (cpu_busy !== 1'b1 || cpu_valid !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL settle2: busy=%b valid=%b addr=%h, want 1 0 0", cpu_busy, cpu_valid, mem_addr);
        end
        cyc();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (cpu_busy !== 1'b0 || cpu_valid !== 1'b1 || cpu_out !== line_out[v*DB +: DB]) begin
            errors++;
            $display("FAIL rehit: busy=%b valid=%b out=%h, want 0 1 %h", cpu_busy, cpu_valid, cpu_out,
                     line_out[v*DB +: DB]);
        end
        exp_hits++;
        exp_victim = (v + 1) % NL;
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int k = 0; k < NL + 1; k++) test_miss($urandom_range(0, 4));
    endtask

    task automatic test_drop();
        randomize_lines();
        start_request();
        cyc();
        line_miss = 4'b1011;
        #1;
        checks++;
        if (cpu_valid !== 1'b0 || line_fill !== '0) begin
            errors++;
            $display("FAIL partial_miss: valid=%b fill=%b, want 0 0", cpu_valid, line_fill);
        end
        cyc();
        cpu_rdreq = 1'b0; cpu_wrreq = 1'b0; line_valid = 4'b0100;
        #1;
        checks++;
        if (cpu_valid !== 1'b0 || line_fill !== '0) begin
            errors++;
            $display("FAIL drop: valid=%b fill=%b, want 0 0", cpu_valid, line_fill);
        end
        cyc();
        // Back in IDLE: a new request with a hit already present must wait a cycle.
        cpu_rdreq = 1'b1;
        #1;
        checks++;
        if (cpu_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle: valid=%b, want 0", cpu_valid);
        end
        cyc();
        checks++;
        if (cpu_valid !== 1'b1 || cpu_out !== line_out[2*DB +: DB]) begin
            errors++;
            $display("FAIL drop_rehit: valid=%b out=%h, want 1 %h", cpu_valid, cpu_out, line_out[2*DB +: DB]);
        end
        exp_hits++;
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_fill();
        int beats;
        randomize_lines();
        cpu_rdreq = 1'b1;
        cyc();
        line_miss = '1;
        cyc();
        line_miss = '0;
        line_mem_rdreq = '1;
        mem_valid = 1'b1;
        beats = 0;
        while (beats < 10) begin beats++; cyc(); end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_rdreq !== 1'b0 || line_mem_valid !== '0 || cpu_busy !== 1'b0 || mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid_fill: rd=%b lmv=%b busy=%b addr=%h, want 0", mem_rdreq, line_mem_valid,
                     cpu_busy, mem_addr);
        end
        cyc();
        reset = 1'b0;
        clear_inputs();
        exp_victim = 0; exp_hits = 0; exp_misses = 0;
        cyc();
        test_hit();
        test_miss(0);
    endtask

    task automatic test_counters();
        logic [31:0] want_hit, want_miss;
`ifdef DCACHE_CTRL_PERF_EN
        want_hit = 32'(exp_hits); want_miss = 32'(exp_misses);
`else
        want_hit = '0; want_miss = '0;
`endif
        checks++;
        if (hit_count !== want_hit || miss_count !== want_miss) begin
            errors++;
            $display("FAIL perf_counters: hit=%0d miss=%0d, want %0d %0d", hit_count, miss_count, want_hit, want_miss);
        end
    endtask

    task automatic test_perf();
        test_reset();
        for (int k = 0; k < 3; k++) test_hit();
        for (int k = 0; k < 2; k++) test_miss(k * 3);
        test_counters();
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 4; k++) test_hit();
        test_counters();
        test_miss(0);
        test_miss(LW);
        test_counters();
        test_back_to_back();
        test_drop();
        test_counters();
        test_reset_mid_fill();
        test_counters();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Sequences a bank of NUMLINES dcache_line instances: presents each CPU request to all lines, detects a hit or a global miss, and picks a victim line.
- On a miss, issues line_fill to the victim and grants it exclusive use of the single memory-controller port until its flush/fill burst completes.
- Muxes the hitting line's data back to the CPU.
- Sits between the CPU core, the line bank and the memory controller.

Parameters:
- NUMLINES, 4, number of cache lines controlled (power of 2, 2..8).
- LINEWORDS, 32, words per line; fill completes after this many granted mem_valid beats.
- ADDRBITS, 32, address width.
- DATABITS, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDRBITS  CPU request address.
- cpu_rdreq  in  1  read request, held until cpu_valid.
- cpu_wrreq  in  1  write request, held until cpu_valid.
- cpu_out  out  DATABITS  read data.
- cpu_valid  out  1  one-cycle completion strobe.
- cpu_busy  out  1  controller is in a miss sequence.
- line_fill  out  NUMLINES  one-hot fill pulse to the victim line.
- line_out  in  NUMLINES*DATABITS  concatenated line data; line i occupies bits [i*DATABITS +: DATABITS].
- line_valid  in  NUMLINES  per-line hit/valid.
- line_miss  in  NUMLINES  per-line miss.
- line_mem_addr  in  NUMLINES*ADDRBITS  per-line memory address.
- line_mem_rdreq  in  NUMLINES  per-line memory read request.
- line_mem_wrreq  in  NUMLINES  per-line memory write request.
- line_mem_valid  out  NUMLINES  mem_valid routed to the granted line only.
- mem_addr  out  ADDRBITS  to memory controller.
- mem_rdreq  out  1  to memory controller.
- mem_wrreq  out  1  to memory controller.
- mem_valid  in  1  from memory controller.
- hit_count  out  32  hit counter (see Optional Feature).
- miss_count  out  32  miss counter (see Optional Feature).

Behaviour:
- Reset values (async, immediate): all outputs 0; state IDLE; victim pointer 0; beat counter 0.
- States: IDLE, LOOKUP, FILL, SETTLE.
- IDLE:
  - Entered on cpu_rdreq|cpu_wrreq → LOOKUP.
  - If rdreq and wrreq are both asserted, the access is treated as a write.
- LOOKUP (one cycle after request, when line responses are registered):
  - Any line_valid[i]=1 → hit. cpu_valid=1 for one cycle; cpu_out=line_out slice i (lowest i wins if several are set); → IDLE.
  - All line_miss=1 → miss. line_fill[victim]=1 for exactly one cycle; cpu_busy=1; beat counter cleared; → FILL.
  - Otherwise stay in LOOKUP.
- FILL:
  - mem_addr/mem_rdreq/mem_wrreq are driven combinationally from the victim's line_mem_* ports.
  - line_mem_valid[victim]=mem_valid; all other bits 0.
  - Beat counter increments on each mem_valid.
  - mem_wrreq beats (flush) do not count.
  - When count reaches LINEWORDS → SETTLE.
- SETTLE:
  - Holds for 2 cycles to cover the line's breather state.
  - Victim pointer advances (pointer+1, wraps NUMLINES-1→0).
  - cpu_busy drops; → LOOKUP, re-presenting the still-held request, which now hits.
- Outside FILL: mem_rdreq=mem_wrreq=0, mem_addr=0, line_mem_valid=0.
- cpu_valid is never asserted in FILL or SETTLE.
- Request dropped by the CPU during LOOKUP → return to IDLE, no cpu_valid, no fill.
- mem_valid outside FILL is ignored.
- Reset asserted mid-FILL → immediate return to IDLE with memory requests deasserted; the lines are reset by the same system reset.
- Beat counter width is log2(LINEWORDS)+1.
- Counter saturation is not needed within one fill.

Optional Feature:
- Macro: DCACHE_CTRL_PERF_EN.
- Defined:
  - hit_count increments on each LOOKUP hit.
  - miss_count increments on each line_fill pulse.
  - Both wrap at 2^32 and clear on reset.
- Undefined: hit_count and miss_count are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset, then rdreq at 0x0000_0100 with line_valid=4'b0010 on the following cycle → cpu_valid pulse 1 cycle later, cpu_out=line 1 data, no line_fill.
- All line_miss=1 with victim pointer 0 → line_fill=4'b0001 for exactly 1 cycle; mem_rdreq mirrors line 0; 32 mem_valid beats → SETTLE, cpu_busy low after 2 cycles, next fill selects line 1.
- Four successive misses → line_fill pulses 0001, 0010, 0100, 1000, then wraps to 0001.
- Victim performs a 32-beat mem_wrreq flush before its read fill → only read-side mem_valid beats counted; FILL exits after exactly 32 of them.
- Reset asserted at fill beat 10 → mem_rdreq=0 and state IDLE in the same cycle; new request after reset is handled normally.
- With DCACHE_CTRL_PERF_EN: 3 hits + 2 misses → hit_count=5 (3 + 2 post-fill rehits), miss_count=2; without the macro both read 0.
